// File: rtl/moving_average_pkg.sv
// Shared constants and helpers for the moving_average_n filter family.
// Optional build macro used by the filter: MOVING_AVERAGE_N_ROUND_EN (round half up).
package moving_average_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_LOG2_WIN = 2;

    typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

    // A sum of 2^log2_win samples needs log2_win extra bits to never overflow.
    function automatic int sum_width(input int data_w, input int log2_win);
        return data_w + log2_win;
    endfunction

endpackage

// File: rtl/moving_average_delay_line.sv
// Shift-enabled delay line holding the last DEPTH accepted samples.
// oldest_o is the sample accepted DEPTH shifts ago (zero while still filling).
module moving_average_delay_line #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] oldest_o
);

    logic [DATA_W-1:0] hist_q [DEPTH];

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
        end else if (shift_en_i) begin
            hist_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    assign oldest_o = hist_q[DEPTH-1];

endmodule

// File: rtl/moving_average_n.sv
// Streaming moving average over the last 2^LOG2_WIN signed samples, 1-cycle latency.
// Build option: define MOVING_AVERAGE_N_ROUND_EN to round half up instead of flooring.
module moving_average_n
    import moving_average_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int LOG2_WIN = DEFAULT_LOG2_WIN
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              clear,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              primed
);

    localparam int SUM_W = sum_width(DATA_W, LOG2_WIN);
    localparam int WIN   = 1 << LOG2_WIN;
    localparam int CNT_W = LOG2_WIN + 1;
    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN);

    logic                     accept;
    logic [DATA_W-1:0]        oldest;
    logic signed [SUM_W-1:0]  in_ext, old_ext, sum_next;
    logic [DATA_W-1:0]        avg;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]         fill_q, fill_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     primed_q, primed_d;

    assign accept = in_valid && !clear;

    moving_average_delay_line #(
        .DATA_W(DATA_W),
        .DEPTH (WIN)
    ) u_delay_line (
        .system1000     (system1000),
        .system1000_rstn(system1000_rstn),
        .clear_i        (clear),
        .shift_en_i     (accept),
        .data_i         (in_data),
        .oldest_o       (oldest)
    );

    // Wraparound in the intermediate add/subtract is harmless: the true sum always fits SUM_W.
    always_comb begin
        in_ext   = {{LOG2_WIN{in_data[DATA_W-1]}}, in_data};
        old_ext  = {{LOG2_WIN{oldest[DATA_W-1]}}, oldest};
        sum_next = sum_q + in_ext - old_ext;
    end

`ifdef MOVING_AVERAGE_N_ROUND_EN
    logic signed [SUM_W:0] round_sum;

    always_comb begin
        round_sum = {sum_next[SUM_W-1], sum_next} + (SUM_W+1)'(WIN / 2);
        avg       = DATA_W'(round_sum >>> LOG2_WIN);
    end
`else
    always_comb begin
        avg = DATA_W'(sum_next >>> LOG2_WIN);
    end
`endif

    always_comb begin
        sum_d       = sum_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        primed_d    = primed_q;
        if (clear) begin
            sum_d    = '0;
            fill_d   = '0;
            primed_d = 1'b0;
        end else if (in_valid) begin
            sum_d       = sum_next;
            out_data_d  = avg;
            out_valid_d = 1'b1;
            if (fill_q != WIN_CNT) fill_d = fill_q + 1'b1;
            primed_d = (fill_d == WIN_CNT);
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            sum_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            primed_q    <= primed_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_moving_average_n.sv
// Bench for moving_average_n: directed vector table on an 8/2 instance, random stream on a 12/5 instance.
// Honours MOVING_AVERAGE_N_ROUND_EN to select floor or round-half-up expectations.
module tb_moving_average_n;

    localparam int SW  = 8;
    localparam int SL  = 2;
    localparam int BW  = 12;
    localparam int BL  = 5;
    localparam int BWIN = 1 << BL;

    logic          clk = 1'b0;
    logic          rstn;
    logic [SW-1:0] sIn;
    logic          sValid, sClear;
    logic [SW-1:0] sOut;
    logic          sOutValid, sPrimed;
    logic [BW-1:0] bIn;
    logic          bValid, bClear;
    logic [BW-1:0] bOut;
    logic          bOutValid, bPrimed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    moving_average_n #(.DATA_W(SW), .LOG2_WIN(SL)) dutSmall (
        .system1000(clk), .system1000_rstn(rstn),
        .in_data(sIn), .in_valid(sValid), .clear(sClear),
        .out_data(sOut), .out_valid(sOutValid), .primed(sPrimed)
    );

    moving_average_n #(.DATA_W(BW), .LOG2_WIN(BL)) dutBig (
        .system1000(clk), .system1000_rstn(rstn),
        .in_data(bIn), .in_valid(bValid), .clear(bClear),
        .out_data(bOut), .out_valid(bOutValid), .primed(bPrimed)
    );

    typedef struct {
        logic v;
        logic c;
        int   d;
        logic ev;
        int   ef;
        int   er;
        logic ep;
    } vec_t;

    vec_t tbl[$];

    // Mean of a window sum by plain integer arithmetic, floored toward -inf.
    function automatic int avgRef(input int s, input int log2w);
        int win = 1 << log2w;
        int q;
`ifdef MOVING_AVERAGE_N_ROUND_EN
        s = s + win / 2;
`endif
        q = s / win;
        if ((s % win) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic c, input int d);
        sValid = v;
        sClear = c;
        sIn    = SW'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic checkSmall(input string name, input logic ev, input int ed, input logic ep);
        checkOutput({name, " out_valid"}, int'(sOutValid), int'(ev));
        checkOutput({name, " out_data"}, int'($signed(sOut)), ed);
        checkOutput({name, " primed"}, int'(sPrimed), int'(ep));
    endtask

    initial begin
        int hist[$];
        int fill, expD, s, bd;
        logic expV, expP, bv, bc;

        rstn = 1'b0;
        sIn = '0; sValid = 1'b0; sClear = 1'b0;
        bIn = '0; bValid = 1'b0; bClear = 1'b0;
        #12;
        checkSmall("reset", 1'b0, 0, 1'b0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        //           v  c  d     ev  floor round ep
        tbl.push_back('{1, 0, 4,    1,  1,    1,    0});
        tbl.push_back('{1, 0, 8,    1,  3,    3,    0});
        tbl.push_back('{1, 0, 12,   1,  6,    6,    0});
        tbl.push_back('{1, 0, 16,   1,  10,   10,   1});
        tbl.push_back('{1, 0, 16,   1,  13,   13,   1});
        tbl.push_back('{0, 0, 99,   0,  13,   13,   1});
        tbl.push_back('{0, 0, 0,    0,  13,   13,   1});
        tbl.push_back('{0, 0, 0,    0,  13,   13,   1});
        tbl.push_back('{1, 1, 100,  0,  13,   13,   0});
        tbl.push_back('{1, 0, 8,    1,  2,    2,    0});
        tbl.push_back('{0, 1, 0,    0,  2,    2,    0});
        tbl.push_back('{1, 0, -1,   1,  -1,   0,    0});
        tbl.push_back('{0, 0, 0,    0,  -1,   0,    0});
        tbl.push_back('{0, 0, 0,    0,  -1,   0,    0});
        tbl.push_back('{0, 0, 0,    0,  -1,   0,    0});
        tbl.push_back('{0, 1, 0,    0,  -1,   0,    0});
        tbl.push_back('{1, 0, -128, 1,  -32,  -32,  0});
        tbl.push_back('{1, 0, -128, 1,  -64,  -64,  0});
        tbl.push_back('{1, 0, -128, 1,  -96,  -96,  0});
        tbl.push_back('{1, 0, -128, 1,  -128, -128, 1});
        tbl.push_back('{1, 0, 127,  1,  -65,  -64,  1});
        tbl.push_back('{1, 0, 127,  1,  -1,   0,    1});
        tbl.push_back('{1, 0, 127,  1,  63,   63,   1});
        tbl.push_back('{1, 0, 127,  1,  127,  127,  1});

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].v, tbl[i].c, tbl[i].d);
`ifdef MOVING_AVERAGE_N_ROUND_EN
            expD = tbl[i].er;
`else
            expD = tbl[i].ef;
`endif
            checkSmall($sformatf("vec%0d", i), tbl[i].ev, expD, tbl[i].ep);
        end

        // Asynchronous reset between edges, then the first sample must see empty history.
        applyStimulus(1'b1, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b0, 20);
        checkSmall("pre-reset", 1'b1, 10, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        checkSmall("async reset", 1'b0, 0, 1'b0);
        #2;
        rstn = 1'b1;
        applyStimulus(1'b1, 1'b0, 40);
        checkSmall("after reset", 1'b1, 10, 1'b0);
        applyStimulus(1'b0, 1'b0, 0);

        // Random stream on the wide instance against a window-of-values model.
        for (int i = 0; i < BWIN; i++) hist.push_back(0);
        fill = 0; expD = 0; expV = 1'b0; expP = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            bv = ($urandom_range(0, 99) < 70);
            bc = ($urandom_range(0, 99) < 3);
            bIn = BW'($urandom);
            bValid = bv;
            bClear = bc;
            bd = int'($signed(bIn));
            @(posedge clk);
            #1;
            if (bc) begin
                for (int i = 0; i < BWIN; i++) hist[i] = 0;
                fill = 0; expV = 1'b0; expP = 1'b0;
            end else if (bv) begin
                hist.push_front(bd);
                void'(hist.pop_back());
                s = 0;
                foreach (hist[k]) s += hist[k];
                expD = avgRef(s, BL);
                expV = 1'b1;
                if (fill < BWIN) fill++;
                expP = (fill == BWIN);
            end else begin
                expV = 1'b0;
            end
            checkOutput($sformatf("rand%0d out_valid", n), int'(bOutValid), int'(expV));
            checkOutput($sformatf("rand%0d out_data", n), int'($signed(bOut)), expD);
            checkOutput($sformatf("rand%0d primed", n), int'(bPrimed), int'(expP));
        end
        bValid = 1'b0;
        bClear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
